// File: rtl/branch_cond_unit_pkg.sv
// Shared types and constants for the branch condition unit: branch kinds,
// ARM condition codes, controller states and the outstanding-flag limit.
package branch_cond_unit_pkg;

   typedef enum logic [1:0] {
      BR_B     = 2'b00,
      BR_CBZ   = 2'b01,
      BR_CBNZ  = 2'b10,
      BR_BCOND = 2'b11
   } br_type_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_HS = 4'd2;
   localparam logic [3:0] COND_LO = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   localparam logic [1:0] PENDING_MAX = 2'd3;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational ARM condition evaluation: codes come in base/inverse pairs,
// so cond[3:1] picks the base test and cond[0] inverts it (except 14/15).
module cond_eval (
   input  logic [3:0] cond,
   input  logic       n,
   input  logic       z,
   input  logic       v,
   input  logic       c,
   output logic       pass
);

   logic base;

   always_comb begin
      base = 1'b1;
      case (cond[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
   end

   assign pass = base ^ (cond[0] & (cond[3:1] != 3'd7));

endmodule

// File: rtl/branch_cond_unit.sv
// Branch resolver: B/CBZ/CBNZ resolve at once; BCOND waits in HOLD until the
// last outstanding flag-setting op retires, then uses the bypassed flags.
//
// Handshake: a branch is accepted on a rising edge where br_valid && br_ready;
// br_ready is high exactly when the controller is IDLE, so it never depends
// on br_valid. Results appear as a one-cycle out_valid pulse with no back-pressure.
module branch_cond_unit
   import branch_cond_unit_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flag_issue,
   output logic             issue_ready,
   input  logic             flag_we,
   input  logic             alu_negative,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_carry_out,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [1:0]       br_type,
   input  logic [3:0]       br_cond,
   input  logic             br_regzero,
   input  logic [WIDTH-1:0] br_pc,
   input  logic [WIDTH-1:0] br_offset,
   input  logic             flush,
   output logic             out_valid,
   output logic             out_taken,
   output logic [WIDTH-1:0] out_target,
   output logic [3:0]       flags,
   output logic             dbg_hold
);

   state_e           state_q, state_d;
   logic [1:0]       pending_q, pending_d;
   logic [3:0]       flags_q, flags_d;
   logic [3:0]       hold_cond_q, hold_cond_d;
   logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
   logic [WIDTH-1:0] hold_off_q, hold_off_d;
   logic             out_valid_q, out_valid_d;
   logic             out_taken_q, out_taken_d;
   logic [WIDTH-1:0] out_target_q, out_target_d;

   logic [3:0]       alu_flags, eff_flags;
   logic [1:0]       sel_type;
   logic [3:0]       sel_cond;
   logic [WIDTH-1:0] sel_pc, sel_off;
   logic             cond_pass, taken, resolve;

   assign alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
   assign eff_flags = flag_we ? alu_flags : flags_q;

   // In HOLD the resolution operates on the latched BCOND, otherwise on the live request.
   assign sel_type = (state_q == ST_HOLD) ? BR_BCOND    : br_type;
   assign sel_cond = (state_q == ST_HOLD) ? hold_cond_q : br_cond;
   assign sel_pc   = (state_q == ST_HOLD) ? hold_pc_q   : br_pc;
   assign sel_off  = (state_q == ST_HOLD) ? hold_off_q  : br_offset;

   cond_eval u_cond_eval (
      .cond (sel_cond),
      .n    (eff_flags[3]),
      .z    (eff_flags[2]),
      .v    (eff_flags[1]),
      .c    (eff_flags[0]),
      .pass (cond_pass)
   );

   always_comb begin
      taken = 1'b1;
      case (sel_type)
         BR_B:    taken = 1'b1;
         BR_CBZ:  taken = br_regzero;
         BR_CBNZ: taken = ~br_regzero;
         default: taken = cond_pass;
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      if (flag_issue && !flag_we && pending_q != PENDING_MAX)
         pending_d = pending_q + 2'd1;
      else if (flag_we && !flag_issue && pending_q != 2'd0)
         pending_d = pending_q - 2'd1;
      flags_d = flag_we ? alu_flags : flags_q;
   end

   always_comb begin
      state_d      = state_q;
      hold_cond_d  = hold_cond_q;
      hold_pc_d    = hold_pc_q;
      hold_off_d   = hold_off_q;
      out_valid_d  = 1'b0;
      out_taken_d  = out_taken_q;
      out_target_d = out_target_q;
      resolve      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (br_valid) begin
               if (br_type != BR_BCOND || pending_q == 2'd0 ||
                   (pending_q == 2'd1 && flag_we)) begin
                  resolve = 1'b1;
               end else begin
                  state_d     = ST_HOLD;
                  hold_cond_d = br_cond;
                  hold_pc_d   = br_pc;
                  hold_off_d  = br_offset;
               end
            end
         end
         default: begin
            if (flag_we && pending_q == 2'd1) begin
               resolve = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end else if (resolve) begin
         out_valid_d  = 1'b1;
         out_taken_d  = taken;
         out_target_d = taken ? (sel_pc + sel_off) : (sel_pc + WIDTH'(4));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pending_q    <= 2'd0;
         flags_q      <= 4'd0;
         hold_cond_q  <= 4'd0;
         hold_pc_q    <= '0;
         hold_off_q   <= '0;
         out_valid_q  <= 1'b0;
         out_taken_q  <= 1'b0;
         out_target_q <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         flags_q      <= flags_d;
         hold_cond_q  <= hold_cond_d;
         hold_pc_q    <= hold_pc_d;
         hold_off_q   <= hold_off_d;
         out_valid_q  <= out_valid_d;
         out_taken_q  <= out_taken_d;
         out_target_q <= out_target_d;
      end
   end

   assign issue_ready = (pending_q != PENDING_MAX);
   assign br_ready    = (state_q == ST_IDLE);
   assign dbg_hold    = (state_q == ST_HOLD);
   assign out_valid   = out_valid_q;
   assign out_taken   = out_taken_q;
   assign out_target  = out_target_q;
   assign flags       = flags_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed and random stimulus for branch_cond_unit, checked each cycle
// against a behavioural model of pending count, flags and branch holding.
module tb_branch_cond_unit;
   import branch_cond_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flag_issue, flag_we;
   logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
   logic        br_valid, br_regzero, flush;
   logic [1:0]  br_type;
   logic [3:0]  br_cond;
   logic [63:0] br_pc, br_offset;
   logic        issue_ready, br_ready, out_valid, out_taken, dbg_hold;
   logic [63:0] out_target;
   logic [3:0]  flags;

   int checks = 0;
   int failures = 0;

   // model state
   int          m_pend;
   logic [3:0]  m_flags;
   bit          m_hold;
   logic [3:0]  m_hcond;
   logic [63:0] m_hpc, m_hoff;

   branch_cond_unit #(.WIDTH(64)) dut (
      .clk(clk), .reset(reset), .flag_issue(flag_issue), .issue_ready(issue_ready),
      .flag_we(flag_we), .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
      .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type), .br_cond(br_cond),
      .br_regzero(br_regzero), .br_pc(br_pc), .br_offset(br_offset), .flush(flush),
      .out_valid(out_valid), .out_taken(out_taken), .out_target(out_target),
      .flags(flags), .dbg_hold(dbg_hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_taken(input logic [1:0] t, input logic [3:0] c,
                                  input bit rz, input logic [3:0] f);
      bit n, z, v, cy;
      n = f[3]; z = f[2]; v = f[1]; cy = f[0];
      if (t == 2'b00) return 1'b1;
      if (t == 2'b01) return rz;
      if (t == 2'b10) return !rz;
      case (c)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_HS: return cy;
         COND_LO: return !cy;
         COND_MI: return n;
         COND_PL: return !n;
         COND_VS: return v;
         COND_VC: return !v;
         COND_HI: return cy && !z;
         COND_LS: return !(cy && !z);
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return !z && (n == v);
         COND_LE: return !(!z && (n == v));
         default: return 1'b1;
      endcase
   endfunction

   task automatic m_reset();
      m_pend = 0; m_flags = 4'd0; m_hold = 0;
   endtask

   task automatic drive(input bit fi, input bit fw, input logic [3:0] alu, input bit bv,
                        input logic [1:0] bt, input logic [3:0] bc, input bit rz,
                        input logic [63:0] pc, input logic [63:0] off, input bit fl);
      flag_issue = fi; flag_we = fw;
      {alu_negative, alu_zero, alu_overflow, alu_carry_out} = alu;
      br_valid = bv; br_type = bt; br_cond = bc; br_regzero = rz;
      br_pc = pc; br_offset = off; flush = fl;
   endtask

   task automatic idle();
      drive(0, 0, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0);
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic cycle();
      logic [3:0]  eff;
      bit          exp_v, exp_t, res;
      logic [63:0] exp_tgt, pc, off;
      logic [1:0]  t;
      logic [3:0]  c;
      chk("br_ready", br_ready, !m_hold);
      chk("issue_ready", issue_ready, m_pend < 3);
      eff = flag_we ? {alu_negative, alu_zero, alu_overflow, alu_carry_out} : m_flags;
      res = 0; t = br_type; c = br_cond; pc = br_pc; off = br_offset;
      if (!m_hold) begin
         if (br_valid) begin
            if (br_type != 2'b11 || m_pend == 0 || (m_pend == 1 && flag_we)) res = 1;
            else begin
               m_hold = 1; m_hcond = br_cond; m_hpc = br_pc; m_hoff = br_offset;
            end
         end
      end else if (flag_we && m_pend == 1) begin
         res = 1; m_hold = 0; t = 2'b11; c = m_hcond; pc = m_hpc; off = m_hoff;
      end
      exp_t = m_taken(t, c, br_regzero, eff);
      exp_tgt = exp_t ? pc + off : pc + 64'd4;
      exp_v = res;
      if (flush) begin exp_v = 0; m_hold = 0; end
      if (flag_issue && !flag_we && m_pend < 3) m_pend++;
      else if (flag_we && !flag_issue && m_pend > 0) m_pend--;
      if (flag_we) m_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
      @(posedge clk); #1;
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
         chk("out_taken", out_taken, exp_t);
         chk("out_target", out_target, exp_tgt);
      end
      chk("flags", flags, m_flags);
      chk("dbg_hold", dbg_hold, m_hold);
   endtask

   task automatic chk_reset_values();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_taken", out_taken, 0);
      chk("rst_out_target", out_target, 64'd0);
      chk("rst_flags", flags, 4'd0);
      chk("rst_br_ready", br_ready, 1);
      chk("rst_issue_ready", issue_ready, 1);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      m_reset();
      @(posedge clk); @(posedge clk); #1;
      chk_reset_values();
      reset = 1'b0;

      // Z=1 then BCOND EQ taken to 0x1040
      drive(0, 1, 4'b0100, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      drive(0, 0, 4'd0, 1, BR_BCOND, COND_EQ, 0, 64'h1000, 64'h40, 0); cycle();
      chk("eq_taken", out_taken, 1);
      chk("eq_target", out_target, 64'h1040);

      // BCOND NE waits for the outstanding flag op
      drive(1, 0, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      drive(0, 0, 4'd0, 1, BR_BCOND, COND_NE, 0, 64'h2000, 64'h80, 0); cycle();
      idle(); cycle();
      chk("ne_hold_br_ready", br_ready, 0);
      drive(0, 1, 4'b0000, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      chk("ne_valid", out_valid, 1);
      chk("ne_taken", out_taken, 1);
      chk("ne_target", out_target, 64'h2080);

      // BCOND GE resolves with same-cycle flag_we bypass
      drive(1, 0, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      drive(0, 1, 4'b1010, 1, BR_BCOND, COND_GE, 0, 64'h3000, 64'h10, 0); cycle();
      chk("ge_valid", out_valid, 1);
      chk("ge_taken", out_taken, 1);
      chk("ge_no_hold", br_ready, 1);

      // CBNZ not taken, pc+4 wraps to zero
      drive(0, 0, 4'd0, 1, BR_CBNZ, 4'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 0); cycle();
      chk("cbnz_taken", out_taken, 0);
      chk("cbnz_target", out_target, 64'h0);

      // saturating pending count
      repeat (3) begin drive(1, 0, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle(); end
      chk("sat_issue_ready", issue_ready, 0);
      drive(1, 0, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      drive(1, 1, 4'b0001, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      chk("sat_both_issue_ready", issue_ready, 0);
      repeat (3) begin drive(0, 1, 4'b0001, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle(); end
      chk("drain_issue_ready", issue_ready, 1);
      drive(0, 1, 4'b0110, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      chk("we_at_zero_flags", flags, 4'b0110);

      // flush beats a resolving flag_we
      drive(1, 0, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      drive(0, 0, 4'd0, 1, BR_BCOND, COND_MI, 0, 64'h4000, 64'h8, 0); cycle();
      drive(0, 1, 4'b1001, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 1); cycle();
      chk("flush_valid", out_valid, 0);
      chk("flush_flags", flags, 4'b1001);
      chk("flush_ready", br_ready, 1);
      idle(); cycle();
      chk("flush_pending0", issue_ready, 1);

      // reset mid-HOLD
      drive(1, 0, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      drive(0, 0, 4'd0, 1, BR_BCOND, COND_PL, 0, 64'h5000, 64'h8, 0); cycle();
      idle();
      #2 reset = 1'b1;
      #1 chk_reset_values();
      m_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      drive(0, 1, 4'd0, 0, 2'b00, 4'd0, 0, 64'd0, 64'd0, 0); cycle();
      idle(); cycle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
               $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               $urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 15) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
